// File: rtl/updown_mod_counter.sv
// rtl/updown_mod_counter.sv - up/down modulo counter with runtime limit, wrap/saturate mode and cascade flag
module updown_mod_counter #(
    parameter int WIDTH    = 8,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             enab,
    input  logic             dir,
    input  logic [WIDTH-1:0] cnt_max,
    input  logic [WIDTH-1:0] cnt_in,
    output logic [WIDTH-1:0] cnt_out,
    output logic             tc,
    output logic             wrap
);

    logic             terminal;
    logic             over_range;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] term_val;

    // Compare before stepping so the increment can never overflow WIDTH bits.
    assign terminal   = dir ? (cnt_out >= cnt_max) : (cnt_out == '0);
    assign over_range = cnt_out > cnt_max;
    assign tc         = enab & ~load & ~rst & terminal;
    assign load_val   = (cnt_in > cnt_max) ? cnt_max : cnt_in;

    always_comb begin
        term_val = '0;
        if (dir) begin
            term_val = SATURATE ? cnt_max : '0;
        end else begin
            term_val = SATURATE ? '0 : cnt_max;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_out <= '0;
            wrap    <= 1'b0;
        end else begin
            // tc already excludes load, so a registered copy is exactly the wrap event.
            wrap <= tc;
            if (load) begin
                cnt_out <= load_val;
            end else if (enab) begin
                if (terminal) begin
                    cnt_out <= term_val;
                end else if (dir) begin
                    cnt_out <= cnt_out + 1'b1;
                end else if (over_range) begin
                    cnt_out <= cnt_max;
                end else begin
                    cnt_out <= cnt_out - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_updown_mod_counter.sv
// tb/tb_updown_mod_counter.sv - randomized self-checking bench for updown_mod_counter
module tb_updown_mod_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1, load = 1'b0, enab = 1'b0, dir = 1'b1;
    logic [3:0] cnt_max = 4'd15, cnt_in = 4'd0;
    logic [3:0] out_w, out_s;
    logic       tc_w, tc_s, wrap_w, wrap_s;

    logic       c_rst = 1'b1, c_en = 1'b0, c_zero = 1'b0, c_up = 1'b1;
    logic [3:0] c_max = 4'd15, c_in = 4'd0;
    logic [3:0] c0_out, c1_out;
    logic       c0_tc, c1_tc, c0_wrap, c1_wrap;

    updown_mod_counter #(.WIDTH(4), .SATURATE(1'b0)) dut_w (
        .clk(clk), .rst(rst), .load(load), .enab(enab), .dir(dir),
        .cnt_max(cnt_max), .cnt_in(cnt_in), .cnt_out(out_w), .tc(tc_w), .wrap(wrap_w));
    updown_mod_counter #(.WIDTH(4), .SATURATE(1'b1)) dut_s (
        .clk(clk), .rst(rst), .load(load), .enab(enab), .dir(dir),
        .cnt_max(cnt_max), .cnt_in(cnt_in), .cnt_out(out_s), .tc(tc_s), .wrap(wrap_s));
    updown_mod_counter #(.WIDTH(4), .SATURATE(1'b0)) stage0 (
        .clk(clk), .rst(c_rst), .load(c_zero), .enab(c_en), .dir(c_up),
        .cnt_max(c_max), .cnt_in(c_in), .cnt_out(c0_out), .tc(c0_tc), .wrap(c0_wrap));
    updown_mod_counter #(.WIDTH(4), .SATURATE(1'b0)) stage1 (
        .clk(clk), .rst(c_rst), .load(c_zero), .enab(c0_tc), .dir(c_up),
        .cnt_max(c_max), .cnt_in(c_in), .cnt_out(c1_out), .tc(c1_tc), .wrap(c1_wrap));

    int n_tests = 0;
    int n_fail  = 0;
    int exp_w = 0, exp_s = 0;
    bit expw_wrap = 1'b0, exps_wrap = 1'b0;

    // Reference: the legal range 0..m is a ring of m+1 values; out-of-range counts re-enter it.
    function automatic void ref_step(input int c, input int m, input bit r, input bit ld,
                                     input bit en, input bit d, input bit sat, input int din,
                                     output int nc, output bit ev);
        nc = c;
        ev = 1'b0;
        if (r) begin
            nc = 0;
        end else if (ld) begin
            nc = (din < m) ? din : m;
        end else if (en && d) begin
            ev = (c >= m);
            if (sat) nc = (c + 1 > m) ? m : c + 1;
            else     nc = (c > m) ? 0 : (c + 1) % (m + 1);
        end else if (en) begin
            ev = (c == 0);
            if (c > m)    nc = m;
            else if (sat) nc = (c - 1 < 0) ? 0 : c - 1;
            else          nc = (c + m) % (m + 1);
        end
    endfunction

    task automatic cycle();
        int nw, ns;
        bit ww, ws;
        ref_step(exp_w, int'(cnt_max), rst, load, enab, dir, 1'b0, int'(cnt_in), nw, ww);
        ref_step(exp_s, int'(cnt_max), rst, load, enab, dir, 1'b1, int'(cnt_in), ns, ws);
        @(posedge clk);
        @(negedge clk);
        exp_w = nw; exp_s = ns; expw_wrap = ww; exps_wrap = ws;
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b1; cnt_in = 4'd9; enab = 1'b1; dir = 1'b1; cnt_max = 4'd15;
        #1;
        n_tests++;
        if (tc_w !== 1'b0) begin n_fail++; $display("FAIL reset_tc_during got=%b want=0", tc_w); end
        cycle();
        n_tests++;
        if (out_w !== 4'd0 || wrap_w !== 1'b0 || tc_w !== 1'b0) begin
            n_fail++; $display("FAIL reset_w got cnt=%0d wrap=%b tc=%b want 0/0/0", out_w, wrap_w, tc_w);
        end
        n_tests++;
        if (out_s !== 4'd0 || wrap_s !== 1'b0 || tc_s !== 1'b0) begin
            n_fail++; $display("FAIL reset_s got cnt=%0d wrap=%b tc=%b want 0/0/0", out_s, wrap_s, tc_s);
        end
        rst = 1'b0; load = 1'b0; enab = 1'b0;
    endtask

    task automatic test_up_wrap();
        int seq [7] = '{1, 2, 3, 4, 5, 0, 1};
        int prev;
        rst = 1'b1; cycle(); rst = 1'b0;
        cnt_max = 4'd5; dir = 1'b1; enab = 1'b1; load = 1'b0;
        for (int i = 0; i < 7; i++) begin
            prev = (i == 0) ? 0 : seq[i-1];
            #1;
            n_tests++;
            if (tc_w !== (prev == 5)) begin
                n_fail++; $display("FAIL up_tc step=%0d got=%b want=%b", i, tc_w, prev == 5);
            end
            cycle();
            n_tests++;
            if (out_w !== 4'(seq[i]) || wrap_w !== (i == 5)) begin
                n_fail++; $display("FAIL up_seq step=%0d got cnt=%0d wrap=%b want cnt=%0d wrap=%b",
                                   i, out_w, wrap_w, seq[i], i == 5);
            end
        end
        enab = 1'b0;
    endtask

    task automatic test_down();
        int seq_w [4] = '{1, 0, 5, 4};
        int seq_s [4] = '{1, 0, 0, 0};
        cnt_max = 4'd5; load = 1'b1; cnt_in = 4'd2; enab = 1'b0;
        cycle();
        n_tests++;
        if (out_w !== 4'd2 || out_s !== 4'd2) begin
            n_fail++; $display("FAIL down_load got w=%0d s=%0d want 2/2", out_w, out_s);
        end
        load = 1'b0; enab = 1'b1; dir = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            n_tests++;
            if (out_w !== 4'(seq_w[i]) || wrap_w !== (i == 2)) begin
                n_fail++; $display("FAIL down_wrap step=%0d got cnt=%0d wrap=%b want cnt=%0d wrap=%b",
                                   i, out_w, wrap_w, seq_w[i], i == 2);
            end
            n_tests++;
            if (out_s !== 4'(seq_s[i]) || wrap_s !== (i >= 2)) begin
                n_fail++; $display("FAIL down_sat step=%0d got cnt=%0d wrap=%b want cnt=%0d wrap=%b",
                                   i, out_s, wrap_s, seq_s[i], i >= 2);
            end
        end
        enab = 1'b0;
    endtask

    task automatic test_load_clamp();
        cnt_max = 4'd7; load = 1'b1; enab = 1'b1; cnt_in = 4'd12; dir = 1'b1;
        #1;
        n_tests++;
        if (tc_w !== 1'b0) begin n_fail++; $display("FAIL clamp_tc_load got=%b want=0", tc_w); end
        cycle();
        n_tests++;
        if (out_w !== 4'd7 || wrap_w !== 1'b0 || out_s !== 4'd7 || wrap_s !== 1'b0) begin
            n_fail++; $display("FAIL clamp_load got w=%0d/%b s=%0d/%b want 7/0 7/0", out_w, wrap_w, out_s, wrap_s);
        end
        load = 1'b0;
        #1;
        n_tests++;
        if (tc_w !== 1'b1) begin n_fail++; $display("FAIL clamp_tc_term got=%b want=1", tc_w); end
        cycle();
        n_tests++;
        if (out_w !== 4'd0 || wrap_w !== 1'b1 || out_s !== 4'd7 || wrap_s !== 1'b1) begin
            n_fail++; $display("FAIL clamp_step got w=%0d/%b s=%0d/%b want 0/1 7/1", out_w, wrap_w, out_s, wrap_s);
        end
        enab = 1'b0;
    endtask

    task automatic test_limit_lowered();
        cnt_max = 4'd15; load = 1'b1; cnt_in = 4'd10; enab = 1'b0;
        cycle();
        load = 1'b0; cnt_max = 4'd3; dir = 1'b1; enab = 1'b1;
        cycle();
        n_tests++;
        if (out_w !== 4'd0 || wrap_w !== 1'b1 || out_s !== 4'd3 || wrap_s !== 1'b1) begin
            n_fail++; $display("FAIL lower_up got w=%0d/%b s=%0d/%b want 0/1 3/1", out_w, wrap_w, out_s, wrap_s);
        end
        enab = 1'b0; cnt_max = 4'd15; load = 1'b1; cnt_in = 4'd10;
        cycle();
        load = 1'b0; cnt_max = 4'd3; dir = 1'b0; enab = 1'b1;
        #1;
        n_tests++;
        if (tc_w !== 1'b0) begin n_fail++; $display("FAIL lower_down_tc got=%b want=0", tc_w); end
        cycle();
        n_tests++;
        if (out_w !== 4'd3 || wrap_w !== 1'b0 || out_s !== 4'd3 || wrap_s !== 1'b0) begin
            n_fail++; $display("FAIL lower_down got w=%0d/%b s=%0d/%b want 3/0 3/0", out_w, wrap_w, out_s, wrap_s);
        end
        enab = 1'b0;
    endtask

    task automatic test_max_zero();
        rst = 1'b1; cycle(); rst = 1'b0;
        cnt_max = 4'd0; enab = 1'b1;
        for (int i = 0; i < 6; i++) begin
            dir = 1'($urandom);
            #1;
            n_tests++;
            if (tc_w !== 1'b1 || tc_s !== 1'b1) begin
                n_fail++; $display("FAIL zero_tc step=%0d got w=%b s=%b want 1/1", i, tc_w, tc_s);
            end
            cycle();
            n_tests++;
            if (out_w !== 4'd0 || wrap_w !== 1'b1 || out_s !== 4'd0 || wrap_s !== 1'b1) begin
                n_fail++; $display("FAIL zero_hold step=%0d got w=%0d/%b s=%0d/%b want 0/1 0/1",
                                   i, out_w, wrap_w, out_s, wrap_s);
            end
        end
        enab = 1'b0;
    endtask

    task automatic test_random();
        int dummy;
        bit tcw_exp, tcs_exp;
        for (int i = 0; i < 500; i++) begin
            rst  = ($urandom_range(0, 31) == 0);
            load = ($urandom_range(0, 9) == 0);
            enab = ($urandom_range(0, 3) != 0);
            dir  = 1'($urandom);
            cnt_in = 4'($urandom);
            case ($urandom_range(0, 15))
                0:       cnt_max = 4'd0;
                1:       cnt_max = 4'd15;
                2, 3:    cnt_max = 4'($urandom);
                default: cnt_max = cnt_max;
            endcase
            ref_step(exp_w, int'(cnt_max), rst, load, enab, dir, 1'b0, int'(cnt_in), dummy, tcw_exp);
            ref_step(exp_s, int'(cnt_max), rst, load, enab, dir, 1'b1, int'(cnt_in), dummy, tcs_exp);
            #1;
            n_tests++;
            if (tc_w !== tcw_exp || tc_s !== tcs_exp) begin
                n_fail++; $display("FAIL rand_tc iter=%0d got w=%b s=%b want w=%b s=%b", i, tc_w, tc_s, tcw_exp, tcs_exp);
            end
            cycle();
            n_tests++;
            if (out_w !== 4'(exp_w) || wrap_w !== expw_wrap) begin
                n_fail++; $display("FAIL rand_w iter=%0d got cnt=%0d wrap=%b want cnt=%0d wrap=%b",
                                   i, out_w, wrap_w, exp_w, expw_wrap);
            end
            n_tests++;
            if (out_s !== 4'(exp_s) || wrap_s !== exps_wrap) begin
                n_fail++; $display("FAIL rand_s iter=%0d got cnt=%0d wrap=%b want cnt=%0d wrap=%b",
                                   i, out_s, wrap_s, exp_s, exps_wrap);
            end
        end
        rst = 1'b0; load = 1'b0; enab = 1'b0;
    endtask

    task automatic test_cascade();
        logic [7:0] want;
        c_rst = 1'b1; c_en = 1'b0;
        cycle();
        c_rst = 1'b0; c_en = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            cycle();
            want = 8'(i % 256);
            n_tests++;
            if ({c1_out, c0_out} !== want || c0_wrap !== (i % 16 == 0)) begin
                n_fail++; $display("FAIL cascade cyc=%0d got {s1,s0}=%0d wrap0=%b want %0d wrap0=%b",
                                   i, {c1_out, c0_out}, c0_wrap, want, i % 16 == 0);
            end
        end
        c_en = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_up_wrap();
        test_down();
        test_load_clamp();
        test_limit_lowered();
        test_max_zero();
        test_random();
        test_cascade();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/updown_mod_counter.md
# updown_mod_counter

Parametrised successor to the team's loadable up-counter. Adds up/down direction, a runtime modulus limit, a wrap-or-saturate mode, a combinational terminal-count flag for cascading, and a registered wrap pulse. It is used for timers, address sequencers and cascaded prescalers anywhere in the datapath.

## Interface

Parameters:
- WIDTH, default 8: counter width in bits; legal range 2..32.
- SATURATE, default 0: overflow mode. 0 = wrap around at the limit; 1 = hold at the limit.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- load  input  1  when high, loads cnt_in (clamped) on the next edge.
- enab  input  1  count enable.
- dir  input  1  count direction: 1 = up, 0 = down.
- cnt_max  input  WIDTH  runtime upper limit; the legal count range is 0..cnt_max inclusive.
- cnt_in  input  WIDTH  value to load.
- cnt_out  output  WIDTH  registered count.
- tc  output  1  combinational terminal-count flag; usable as the enab of the next cascaded stage.
- wrap  output  1  registered one-cycle pulse, asserted the cycle after a wrap or saturate event.

## Operation

Update priority per edge is rst > load > enab > hold.
- **rst:** cnt_out ← 0 and wrap ← 0. load and enab are ignored.
- **load:** cnt_out ← min(cnt_in, cnt_max). wrap ← 0. enab is ignored.
- **enab, dir=1, cnt_out < cnt_max:** cnt_out ← cnt_out + 1.
- **enab, dir=1, cnt_out ≥ cnt_max:** this is the terminal case.
  - SATURATE=0: cnt_out ← 0.
  - SATURATE=1: cnt_out ← cnt_max.
  - In both modes wrap ← 1.
- **enab, dir=0, 0 < cnt_out ≤ cnt_max:** cnt_out ← cnt_out − 1.
- **enab, dir=0, cnt_out > cnt_max:** cnt_out ← cnt_max. This re-enters the range; it is not a wrap event, so wrap ← 0.
- **enab, dir=0, cnt_out == 0:** this is the terminal case.
  - SATURATE=0: cnt_out ← cnt_max.
  - SATURATE=1: cnt_out ← 0.
  - In both modes wrap ← 1.
- **Otherwise:** cnt_out holds and wrap ← 0.

Terminal-count flag:
- tc = enab & ~load & ~rst & terminal.
- terminal = (dir ? cnt_out ≥ cnt_max : cnt_out == 0).

Arithmetic and width rules:
- All arithmetic is WIDTH bits. No intermediate result is allowed to overflow: the compare is done before the increment.
- cnt_max = 0 is legal. The counter then stays at 0, and with enab=1 it pulses tc every cycle and holds wrap at 1.
- cnt_max = 2^WIDTH−1 gives natural modulo-2^WIDTH behaviour.
- cnt_max may change at any cycle. The new value applies to the compare on that same edge.

## Timing

Latency:
- cnt_out and wrap change only on the rising edge of clk. Load, count and reset all take effect one cycle after being sampled.
- tc is combinational from cnt_out, cnt_max, dir, enab, load and rst, with zero latency. It is high in the cycle before the terminal edge.
- wrap is high in the cycle after the edge where the terminal action occurred. It equals tc registered.

Reset values: cnt_out = 0, wrap = 0. tc follows its equation (0 while rst is high).

Simultaneous events and boundary conditions:
- **Reset mid-count:** a reset overrides any in-progress wrap. wrap is 0 the next cycle, even if tc would otherwise have fired.
- **Direction change:** dir may toggle every cycle with no bubble. Each edge uses the dir value sampled at that edge.
- **Load and enab together:** load wins. No count is applied to the loaded value on the same edge.
- **Saturated and still enabled:** a saturated counter with enab held keeps tc=1 and wrap=1 continuously.
- **Cascading:** for stage N, use enab = tc of stage N−1. The chain must form no combinational loop, because tc does not depend on wrap.

## Test plan

All scenarios use WIDTH=4.
- **Reset:** assert rst while load=1, cnt_in=9 and enab=1 → next cycle cnt_out=0, wrap=0, tc=0.
- **Up-count wrap:** SATURATE=0, cnt_max=5, dir=1, enab=1 from 0 → cnt_out sequence 1,2,3,4,5,0,1. tc is high while cnt_out=5. wrap is high in exactly the cycle cnt_out=0.
- **Down-count wrap and saturate:**
  - SATURATE=0, cnt_max=5, load 2 then count down → 1,0,5,4, with wrap high when cnt_out=5.
  - Repeat with SATURATE=1 → 1,0,0,0, with wrap high from the cycle after cnt_out first reaches 0.
- **Load clamp and priority:**
  - cnt_max=7, load=1, enab=1, cnt_in=12 → cnt_out=7, wrap=0.
  - Then load=0, dir=1 → cnt_out=0, wrap=1.
- **Limit lowered below the count:**
  - cnt_out=10, set cnt_max=3, dir=1, enab=1 → next cnt_out=0, wrap=1.
  - Repeat with dir=0 → next cnt_out=3, wrap=0.
- **Cascade:** two instances with cnt_max=15, stage1.enab=tc0, run 40 cycles → counts are {stage1, stage0} = 40 mod 256. stage1 advances exactly when stage0 goes 15→0.
